// File: rtl/beat_pkg.sv
// Shared beat interface definitions: intensity codes, start-amplitude table, player state.
// Latency: n/a (package only).
// Backpressure: n/a.
package beat_pkg;

  localparam logic [1:0] INT_NONE = 2'd0;
  localparam logic [1:0] INT_LOW  = 2'd1;
  localparam logic [1:0] INT_MID  = 2'd2;
  localparam logic [1:0] INT_HIGH = 2'd3;

  typedef enum logic {IDLE, PLAY} state_t;

  // Start amplitude per intensity; 15-bit unsigned so +/- fits a 16-bit sample.
  function automatic logic [14:0] amp_for_intensity(input logic [1:0] intensity);
    logic [14:0] amp;
    case (intensity)
      INT_LOW:  amp = 15'h1000;
      INT_MID:  amp = 15'h2000;
      INT_HIGH: amp = 15'h3FFF;
      default:  amp = 15'h0000;
    endcase
    return amp;
  endfunction

endpackage

// File: rtl/beat_envelope.sv
// Amplitude envelope: holds amp and a decay counter, applying a geometric decay step every DECAY_SAMPLES.
// Latency: load/step take effect on the next clock; note_done is combinational with the final step.
// Backpressure: none; one step per i_step strobe.
module beat_envelope #(
  parameter int unsigned DECAY_SAMPLES = 240,
  parameter int unsigned DECAY_SHIFT   = 3,
  parameter int unsigned MIN_AMP       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [14:0] i_load_amp,
  input  logic        i_step,
  output logic [14:0] o_amp,
  output logic        o_note_done
);

  logic [14:0] r_amp;
  logic [15:0] r_decay_cnt;
  logic [14:0] w_decayed;
  logic        w_wrap;
  logic        w_below;

  assign w_decayed   = r_amp - (r_amp >> DECAY_SHIFT);
  assign w_wrap      = (r_decay_cnt == 16'(DECAY_SAMPLES - 1));
  assign w_below     = (w_decayed < 15'(MIN_AMP));
  assign o_note_done = i_step && w_wrap && w_below;
  assign o_amp       = r_amp;

  // Load on trigger, otherwise count samples and decay on each counter wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_amp       <= '0;
      r_decay_cnt <= '0;
    end else if (i_load) begin
      r_amp       <= i_load_amp;
      r_decay_cnt <= '0;
    end else if (i_step) begin
      if (w_wrap) begin
        r_decay_cnt <= '0;
        r_amp       <= w_below ? 15'd0 : w_decayed;
      end else begin
        r_decay_cnt <= r_decay_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/beat_tone_player.sv
// Beat consumer: edge-detects beats and plays a decaying square-wave burst, one sample per codec request.
// Latency: sample_req at N -> sample_valid/sample_out at N+1; trigger heard from the next request on.
// Backpressure: none; sustains a request every cycle, refused beats are counted in drop_count.
module beat_tone_player
  import beat_pkg::*;
#(
  parameter int unsigned HALF_PERIOD   = 25,
  parameter int unsigned DECAY_SAMPLES = 240,
  parameter int unsigned DECAY_SHIFT   = 3,
  parameter int unsigned MIN_AMP       = 16,
  parameter int unsigned MIN_GAP       = 2400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        beat_en,
  input  logic [1:0]  beat_intensity,
  input  logic        sample_req,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        playing,
  output logic [7:0]  drop_count
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_beat_prev;
  logic [1:0]  r_cur_int;
  logic [7:0]  r_phase;
  logic        r_neg;
  logic [15:0] r_gap;
  logic [15:0] r_sample;
  logic        r_valid;
  logic [7:0]  r_drop;

  logic        w_trig;
  logic        w_accept;
  logic        w_refuse;
  logic        w_step;
  logic [14:0] w_amp;
  logic [15:0] w_amp16;
  logic        w_note_done;

  // A restart needs the refractory gap expired and no drop in intensity.
  assign w_trig   = beat_en && !r_beat_prev && (beat_intensity != INT_NONE);
  assign w_accept = w_trig && ((r_state == IDLE) ||
                               ((r_gap == 16'd0) && (beat_intensity >= r_cur_int)));
  assign w_refuse = w_trig && !w_accept;
  // A trigger load overrides the per-sample advance in the same cycle.
  assign w_step   = sample_req && (r_state == PLAY) && !w_accept;
  assign w_amp16  = {1'b0, w_amp};

  beat_envelope #(
    .DECAY_SAMPLES (DECAY_SAMPLES),
    .DECAY_SHIFT   (DECAY_SHIFT),
    .MIN_AMP       (MIN_AMP)
  ) u_env (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_load_amp  (amp_for_intensity(beat_intensity)),
    .i_step      (w_step),
    .o_amp       (w_amp),
    .o_note_done (w_note_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state: accepted trigger starts/restarts a note; final decay step ends it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = PLAY;
      PLAY: begin
        if (w_accept)         w_state_nxt = PLAY;
        else if (w_note_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Edge register, note intensity, square-wave phase/polarity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_prev <= 1'b0;
      r_cur_int   <= INT_NONE;
      r_phase     <= '0;
      r_neg       <= 1'b0;
    end else begin
      r_beat_prev <= beat_en;
      if (w_accept) begin
        r_cur_int <= beat_intensity;
        r_phase   <= '0;
        r_neg     <= 1'b0;
      end else if (w_step) begin
        if (r_phase == 8'(HALF_PERIOD - 1)) begin
          r_phase <= '0;
          r_neg   <= ~r_neg;
        end else begin
          r_phase <= r_phase + 8'd1;
        end
      end
    end
  end

  // Refractory gap counter and saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gap  <= '0;
      r_drop <= '0;
    end else begin
      if (w_accept)
        r_gap <= 16'(MIN_GAP);
      else if (sample_req && (r_gap != 16'd0))
        r_gap <= r_gap - 16'd1;
      if (w_refuse && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'd1;
    end
  end

  // Output sample register built from pre-update state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= sample_req;
      if (sample_req)
        r_sample <= (r_state == PLAY) ? (r_neg ? -w_amp16 : w_amp16) : 16'd0;
    end
  end

  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign playing      = (r_state == PLAY);
  assign drop_count   = r_drop;

endmodule

// File: tb/tb_beat_tone_player.sv
// Directed bench for beat_tone_player using two parameterisations sharing one stimulus.
// Latency: checks sample one cycle after each request.
// Backpressure: none exercised; fixed-length stimulus only.
module tb_beat_tone_player;

  logic        clk;
  logic        rst;
  logic        beat_en;
  logic [1:0]  beat_intensity;
  logic        sample_req;

  logic [15:0] a_out, b_out;
  logic        a_vld, b_vld;
  logic        a_play, b_play;
  logic [7:0]  a_drop, b_drop;

  int checks;
  int failures;

  // Fast-phase instance: short half period and gap, long decay.
  beat_tone_player #(
    .HALF_PERIOD(4), .DECAY_SAMPLES(240), .DECAY_SHIFT(3), .MIN_AMP(16), .MIN_GAP(10)
  ) dut_a (
    .clk(clk), .rst(rst), .beat_en(beat_en), .beat_intensity(beat_intensity),
    .sample_req(sample_req), .sample_out(a_out), .sample_valid(a_vld),
    .playing(a_play), .drop_count(a_drop)
  );

  // Fast-decay instance.
  beat_tone_player #(
    .HALF_PERIOD(25), .DECAY_SAMPLES(2), .DECAY_SHIFT(1), .MIN_AMP(16), .MIN_GAP(2400)
  ) dut_b (
    .clk(clk), .rst(rst), .beat_en(beat_en), .beat_intensity(beat_intensity),
    .sample_req(sample_req), .sample_out(b_out), .sample_valid(b_vld),
    .playing(b_play), .drop_count(b_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    sample_req     = 1'b0;
    beat_en        = 1'b0;
    beat_intensity = 2'd0;
    rst            = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic req_sample;
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
  endtask

  task automatic pulse_beat(input logic [1:0] intensity);
    beat_en        = 1'b1;
    beat_intensity = intensity;
    tick();
    beat_en = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    sample_req = 1'b0;
    beat_en    = 1'b0;
    rst        = 1'b0;
    #2;
    checks++;
    if (a_out !== 16'h0 || a_vld !== 1'b0 || a_play !== 1'b0 || a_drop !== 8'h0) begin
      failures++;
      $display("FAIL reset_state out=%h vld=%b play=%b drop=%0d required 0/0/0/0",
               a_out, a_vld, a_play, a_drop);
    end
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      req_sample();
      checks++;
      if (a_vld !== 1'b1 || a_out !== 16'h0 || a_play !== 1'b0) begin
        failures++;
        $display("FAIL idle_sample[%0d] vld=%b out=%h play=%b required 1/0000/0", i, a_vld, a_out, a_play);
      end
      tick();
      checks++;
      if (a_vld !== 1'b0) begin
        failures++;
        $display("FAIL idle_vld_pulse[%0d] vld=%b required 0", i, a_vld);
      end
    end
  endtask

  task automatic test_square_wave;
    logic [15:0] exp;
    do_reset();
    pulse_beat(2'd2);
    for (int k = 1; k <= 8; k++) begin
      req_sample();
      exp = (k <= 4) ? 16'h2000 : 16'hE000;
      checks++;
      if (a_vld !== 1'b1 || a_out !== exp) begin
        failures++;
        $display("FAIL square[%0d] out=%h vld=%b required %h/1", k, a_out, a_vld, exp);
      end
    end
  endtask

  task automatic test_decay;
    logic [15:0] base;
    logic [15:0] exp;
    do_reset();
    pulse_beat(2'd1);
    base = 16'h1000;
    for (int k = 1; k <= 19; k++) begin
      req_sample();
      exp = (k <= 18) ? (base >> ((k - 1) / 2)) : 16'h0;
      checks++;
      if (b_out !== exp) begin
        failures++;
        $display("FAIL decay[%0d] out=%h required %h", k, b_out, exp);
      end
      if (k == 16) begin
        checks++;
        if (b_play !== 1'b1) begin
          failures++;
          $display("FAIL decay_still_playing play=%b required 1", b_play);
        end
      end
      if (k == 18) begin
        checks++;
        if (b_play !== 1'b0) begin
          failures++;
          $display("FAIL decay_note_end play=%b required 0", b_play);
        end
      end
    end
  endtask

  task automatic test_retrigger;
    do_reset();
    pulse_beat(2'd3);
    for (int k = 0; k < 3; k++) req_sample();
    pulse_beat(2'd3);
    checks++;
    if (a_drop !== 8'd1) begin
      failures++;
      $display("FAIL gap_refuse drop=%0d required 1", a_drop);
    end
    for (int k = 0; k < 11; k++) req_sample();
    checks++;
    if (a_out !== 16'hC001) begin
      failures++;
      $display("FAIL pre_restart out=%h required c001", a_out);
    end
    pulse_beat(2'd1);
    checks++;
    if (a_drop !== 8'd2) begin
      failures++;
      $display("FAIL low_int_refuse drop=%0d required 2", a_drop);
    end
    pulse_beat(2'd3);
    for (int k = 1; k <= 5; k++) begin
      req_sample();
      checks++;
      if (a_out !== ((k <= 4) ? 16'h3FFF : 16'hC001)) begin
        failures++;
        $display("FAIL restart[%0d] out=%h required %h", k, a_out, (k <= 4) ? 16'h3FFF : 16'hC001);
      end
    end
    checks++;
    if (a_drop !== 8'd2) begin
      failures++;
      $display("FAIL restart_drop drop=%0d required 2", a_drop);
    end
  endtask

  task automatic test_level_and_zero;
    do_reset();
    beat_en        = 1'b1;
    beat_intensity = 2'd2;
    for (int i = 0; i < 100; i++) tick();
    beat_en = 1'b0;
    tick();
    checks++;
    if (a_play !== 1'b1 || a_drop !== 8'd0) begin
      failures++;
      $display("FAIL held_beat play=%b drop=%0d required 1/0", a_play, a_drop);
    end
    do_reset();
    pulse_beat(2'd0);
    req_sample();
    checks++;
    if (a_play !== 1'b0 || a_drop !== 8'd0 || a_out !== 16'h0) begin
      failures++;
      $display("FAIL zero_int play=%b drop=%0d out=%h required 0/0/0000", a_play, a_drop, a_out);
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    logic [15:0] exp;
    do_reset();
    pulse_beat(2'd3);
    bad = 0;
    sample_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = (((k - 1) / 4) % 2 == 0) ? 16'h3FFF : 16'hC001;
      if (a_vld !== 1'b1 || a_out !== exp) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL back_to_back bad_samples=%0d required 0", bad);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (a_out !== 16'h0 || a_vld !== 1'b0 || a_play !== 1'b0 || a_drop !== 8'h0) begin
      failures++;
      $display("FAIL async_reset out=%h vld=%b play=%b drop=%0d required 0/0/0/0",
               a_out, a_vld, a_play, a_drop);
    end
    sample_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    req_sample();
    checks++;
    if (a_out !== 16'h0 || a_play !== 1'b0 || a_vld !== 1'b1) begin
      failures++;
      $display("FAIL post_reset out=%h play=%b vld=%b required 0000/0/1", a_out, a_play, a_vld);
    end
    pulse_beat(2'd3);
    for (int i = 0; i < 300; i++) pulse_beat(2'd3);
    checks++;
    if (a_drop !== 8'd255 || b_drop !== 8'd255) begin
      failures++;
      $display("FAIL drop_saturate a=%0d b=%0d required 255/255", a_drop, b_drop);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b0;
    beat_en        = 1'b0;
    beat_intensity = 2'd0;
    sample_req     = 1'b0;
    test_reset();
    test_square_wave();
    test_decay();
    test_retrigger();
    test_level_and_zero();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
